// File: rtl/wb_regbank.sv
// Writeback stage: selects the writeback value, commits it to the 16x32 register
// bank and the flags, forwards the last commit and counts retired instructions.
module wb_regbank #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned DW    = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  input  logic [3:0]    in_WC,
  input  logic [DW-1:0] in_PC,
  input  logic [DW-1:0] in_PR,
  input  logic [DW-1:0] in_alu_res,
  input  logic [3:0]    in_flags,
  input  logic [1:0]    in_S_MXRB,
  input  logic          in_W_RB,
  input  logic [2:0]    in_W_RF,
  input  logic [3:0]    rd_addr_a,
  input  logic [3:0]    rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  output logic [3:0]    out_flags,
  output logic          out_wb_valid,
  output logic [3:0]    out_wb_addr,
  output logic [DW-1:0] out_wb_data,
  output logic [31:0]   out_retired
);

  localparam int unsigned AW = 4;
  localparam int unsigned FW = 4;
  localparam int unsigned CW = 32;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC  = 2'b10;

  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];
  logic [FW-1:0] flags_q, flags_d;
  logic [CW-1:0] retired_q, retired_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;

  logic [DW-1:0] wb_mux_c;
  logic          wr_fire_c;

  // Writeback source select; the reserved code kills the register write.
  always_comb begin
    wb_mux_c = in_alu_res;
    case (in_S_MXRB)
      SRC_ALU: wb_mux_c = in_alu_res;
      SRC_MEM: wb_mux_c = in_PR;
      SRC_PC:  wb_mux_c = in_PC;
      default: wb_mux_c = in_alu_res;
    endcase
  end

  // A write coincident with reset is lost, so it must not bypass either.
  assign wr_fire_c = ENABLE & in_W_RB & (in_S_MXRB != 2'b11) & ~RESET;

  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_fire_c) begin
      regs_d[in_WC] = wb_mux_c;
    end
  end

  // Flag groups: W_RF[2] -> {N,Z}, W_RF[1] -> C, W_RF[0] -> V.
  always_comb begin
    flags_d = flags_q;
    if (ENABLE) begin
      if (in_W_RF[2]) flags_d[3:2] = in_flags[3:2];
      if (in_W_RF[1]) flags_d[1]   = in_flags[1];
      if (in_W_RF[0]) flags_d[0]   = in_flags[0];
    end
  end

  always_comb begin
    retired_d  = ENABLE ? retired_q + CW'(1) : retired_q;
    wb_valid_d = wr_fire_c;
    wb_addr_d  = wr_fire_c ? in_WC    : wb_addr_q;
    wb_data_d  = wr_fire_c ? wb_mux_c : wb_data_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      flags_q    <= '0;
      retired_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
      flags_q    <= flags_d;
      retired_q  <= retired_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Read ports with same-cycle write bypass.
  assign rd_data_a = (wr_fire_c && (in_WC == rd_addr_a)) ? wb_mux_c : regs_q[rd_addr_a];
  assign rd_data_b = (wr_fire_c && (in_WC == rd_addr_b)) ? wb_mux_c : regs_q[rd_addr_b];

  assign out_flags    = flags_q;
  assign out_retired  = retired_q;
  assign out_wb_valid = wb_valid_q;
  assign out_wb_addr  = wb_addr_q;
  assign out_wb_data  = wb_data_q;

endmodule

// File: tb/tb_wb_regbank.sv
// Directed bench for wb_regbank: vector table for the source mux and bypass,
// hand sequences for forwarding, flags, stall, reset and counter wrap.
module tb_wb_regbank;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [3:0]  in_WC;
  logic [31:0] in_PC, in_PR, in_alu_res;
  logic [3:0]  in_flags;
  logic [1:0]  in_S_MXRB;
  logic        in_W_RB;
  logic [2:0]  in_W_RF;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [3:0]  out_flags;
  logic        out_wb_valid;
  logic [3:0]  out_wb_addr;
  logic [31:0] out_wb_data;
  logic [31:0] out_retired;

  int errors = 0;
  int checks = 0;

  wb_regbank dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .in_WC(in_WC), .in_PC(in_PC), .in_PR(in_PR), .in_alu_res(in_alu_res),
    .in_flags(in_flags), .in_S_MXRB(in_S_MXRB), .in_W_RB(in_W_RB), .in_W_RF(in_W_RF),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .out_flags(out_flags), .out_wb_valid(out_wb_valid),
    .out_wb_addr(out_wb_addr), .out_wb_data(out_wb_data),
    .out_retired(out_retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  wc;
    logic [31:0] alu;
    logic [31:0] pr;
    logic [31:0] pc;
    logic        w_rb;
    logic [3:0]  rda;
    logic [31:0] exp_byp;
    logic        exp_valid;
    logic [31:0] exp_store;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b00, 4'd3,  32'h0000_1234, 32'h0,         32'h0,  1'b1, 4'd3,  32'h0000_1234, 1'b1, 32'h0000_1234};
    vecs[1] = '{2'b01, 4'd4,  32'h0,         32'hDEAD_BEEF, 32'h0,  1'b1, 4'd4,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{2'b10, 4'd15, 32'h0,         32'h0,         32'h40, 1'b1, 4'd15, 32'h0000_0040, 1'b1, 32'h0000_0040};
    vecs[3] = '{2'b11, 4'd5,  32'h5555,      32'h5555,      32'h5555, 1'b1, 4'd5, 32'h0,        1'b0, 32'h0};
    vecs[4] = '{2'b00, 4'd7,  32'hAAAA_5555, 32'h0,         32'h0,  1'b1, 4'd7,  32'hAAAA_5555, 1'b1, 32'hAAAA_5555};
    vecs[5] = '{2'b00, 4'd3,  32'h1,         32'h2,         32'h3,  1'b0, 4'd3,  32'h0000_1234, 1'b0, 32'h0000_1234};
    vecs[6] = '{2'b01, 4'd0,  32'h0,         32'h0000_CAFE, 32'h0,  1'b1, 4'd0,  32'h0000_CAFE, 1'b1, 32'h0000_CAFE};

    RESET = 1'b1; ENABLE = 1'b0; in_WC = '0; in_PC = '0; in_PR = '0; in_alu_res = '0;
    in_flags = '0; in_S_MXRB = '0; in_W_RB = 1'b0; in_W_RF = '0; rd_addr_a = '0; rd_addr_b = '0;
    #12;
    chk("reset_flags", 32'(out_flags), 32'h0);
    chk("reset_retired", out_retired, 32'h0);
    chk("reset_valid", 32'(out_wb_valid), 32'h0);
    RESET = 1'b0;
    tick();

    // Source mux, bypass and storage, one vector per write cycle
    for (int i = 0; i < NV; i++) begin
      ENABLE = 1'b1; in_W_RF = '0;
      in_S_MXRB = vecs[i].sel; in_WC = vecs[i].wc;
      in_alu_res = vecs[i].alu; in_PR = vecs[i].pr; in_PC = vecs[i].pc;
      in_W_RB = vecs[i].w_rb; rd_addr_a = vecs[i].rda; rd_addr_b = vecs[i].rda;
      #2;
      chk($sformatf("v%0d_byp_a", i), rd_data_a, vecs[i].exp_byp);
      chk($sformatf("v%0d_byp_b", i), rd_data_b, vecs[i].exp_byp);
      tick();
      ENABLE = 1'b0; in_W_RB = 1'b0;
      #1;
      chk($sformatf("v%0d_store_a", i), rd_data_a, vecs[i].exp_store);
      chk($sformatf("v%0d_store_b", i), rd_data_b, vecs[i].exp_store);
      chk($sformatf("v%0d_valid", i), 32'(out_wb_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_wb_addr", i), 32'(out_wb_addr), 32'(vecs[i].wc));
        chk($sformatf("v%0d_wb_data", i), out_wb_data, vecs[i].exp_byp);
      end
    end
    chk("retired_after_table", out_retired, 32'd7);

    // Bypass on one port only, then back-to-back writes to the same register
    ENABLE = 1'b1; in_W_RB = 1'b1; in_S_MXRB = 2'b00; in_WC = 4'd7; in_alu_res = 32'h1;
    rd_addr_a = 4'd7; rd_addr_b = 4'd3;
    #2;
    chk("byp_diff_a", rd_data_a, 32'h1);
    chk("byp_diff_b", rd_data_b, 32'h1234);
    tick();
    in_alu_res = 32'h2;
    #1;
    chk("b2b_byp_a", rd_data_a, 32'h2);
    tick();
    ENABLE = 1'b0; in_W_RB = 1'b0;
    #1;
    chk("b2b_store_a", rd_data_a, 32'h2);

    // Forward record, then a bubble that offers a write
    ENABLE = 1'b1; in_W_RB = 1'b1; in_WC = 4'd2; in_alu_res = 32'h99; rd_addr_a = 4'd2;
    tick();
    ENABLE = 1'b0; in_alu_res = 32'h77;
    #1;
    chk("fwd_valid", 32'(out_wb_valid), 32'h1);
    chk("fwd_addr", 32'(out_wb_addr), 32'h2);
    chk("fwd_data", out_wb_data, 32'h99);
    chk("stall_no_byp", rd_data_a, 32'h99);
    tick();
    chk("bubble_valid", 32'(out_wb_valid), 32'h0);
    chk("bubble_addr", 32'(out_wb_addr), 32'h2);
    chk("bubble_data", out_wb_data, 32'h99);
    chk("bubble_reg", rd_data_a, 32'h99);
    in_W_RB = 1'b0;

    // Flag groups
    ENABLE = 1'b1; in_flags = 4'b1111; in_W_RF = 3'b010;
    #1;
    chk("flag_no_bypass", 32'(out_flags), 32'h0);
    tick();
    chk("flag_c", 32'(out_flags), 32'b0010);
    in_flags = 4'b1000; in_W_RF = 3'b100;
    tick();
    chk("flag_nz", 32'(out_flags), 32'b1010);
    ENABLE = 1'b0; in_flags = 4'b0101; in_W_RF = 3'b111;
    tick();
    chk("flag_stall", 32'(out_flags), 32'b1010);
    ENABLE = 1'b1; in_flags = 4'b0001; in_W_RF = 3'b001;
    tick();
    chk("flag_v", 32'(out_flags), 32'b1011);
    in_W_RF = '0;

    // Asynchronous reset mid-cycle after a write
    in_W_RB = 1'b1; in_WC = 4'd3; in_alu_res = 32'h55;
    tick();
    ENABLE = 1'b0; in_W_RB = 1'b0; rd_addr_a = 4'd3; rd_addr_b = 4'd15;
    #1;
    chk("pre_reset_valid", 32'(out_wb_valid), 32'h1);
    RESET = 1'b1;
    #1;
    chk("rst_rd_a", rd_data_a, 32'h0);
    chk("rst_rd_b", rd_data_b, 32'h0);
    chk("rst_flags", 32'(out_flags), 32'h0);
    chk("rst_retired", out_retired, 32'h0);
    chk("rst_valid", 32'(out_wb_valid), 32'h0);
    chk("rst_wb_data", out_wb_data, 32'h0);
    #1;
    RESET = 1'b0;
    tick();

    // 5 enabled, 3 stalled, 2 enabled
    ENABLE = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    ENABLE = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    ENABLE = 1'b1;
    for (int k = 0; k < 2; k++) tick();
    ENABLE = 1'b0;
    #1;
    chk("retired_7", out_retired, 32'd7);
    chk("stall_no_write", rd_data_a, 32'h0);

    // Counter wrap from all-ones
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    ENABLE = 1'b1;
    tick();
    ENABLE = 1'b0;
    #1;
    chk("retired_wrap", out_retired, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regbank.md
# wb_regbank

Writeback stage and architectural state of the pipeline. Consumes the EX/MEM→WB pipeline register outputs, selects the writeback value, and commits it to a 16×32 register bank. Also updates the 4-bit flags register and counts retired instructions. Provides two combinational read ports, with same-cycle write bypass, to the decode stage.

## Interface
Parameters:
- NREGS, 16, number of general registers; address width is fixed at 4.
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  writeback commit enable; low = stage stalled/bubble, no state change.
- in_WC  in  4  destination register address.
- in_PC  in  32  PC value for link writes.
- in_PR  in  32  memory read data.
- in_alu_res  in  32  ALU result.
- in_flags  in  4  candidate flags {N,Z,C,V}, bit 3 = N.
- in_S_MXRB  in  2  writeback source select.
- in_W_RB  in  1  register bank write request.
- in_W_RF  in  3  flag write mask: bit2 = N and Z, bit1 = C, bit0 = V.
- rd_addr_a / rd_addr_b  in  4  read port addresses.
- rd_data_a / rd_data_b  out  32  read port data (combinational).
- out_flags  out  4  architectural flags {N,Z,C,V}.
- out_wb_valid  out  1  registered: a register write committed last cycle.
- out_wb_addr  out  4  registered address of that write.
- out_wb_data  out  32  registered data of that write.
- out_retired  out  32  retired-instruction counter.

## Operation
- Writeback mux (combinational) on in_S_MXRB:
  - 00 → in_alu_res.
  - 01 → in_PR.
  - 10 → in_PC.
  - 11 → reserved; it suppresses the register write even when in_W_RB = 1.
- Register write:
  - Fires when ENABLE & in_W_RB & (in_S_MXRB != 11).
  - Writes the mux value to reg[in_WC] on the rising edge.
  - All 16 registers are writable; there is no hardwired zero.
- Flag write: when ENABLE, each out_flags group whose in_W_RF bit is set loads the matching in_flags bits. Groups whose bit is clear hold.
- Read ports:
  - rd_data_x = reg[rd_addr_x].
  - Bypass: if a register write fires this cycle and in_WC == rd_addr_x, rd_data_x equals the mux value instead.
  - Both ports may bypass at the same time.
- Forward record:
  - Each edge, out_wb_valid takes the register-write-fire condition.
  - On a fire, out_wb_addr and out_wb_data load in_WC and the mux value.
  - Otherwise out_wb_addr and out_wb_data hold.
- Retire counter:
  - Increments by 1 on every edge where ENABLE = 1, whether or not any register or flag write occurs.
  - Wraps from 0xFFFFFFFF to 0. No saturation.
- ENABLE = 0:
  - No register, flag or counter change.
  - out_wb_valid loads 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - All 16 registers, out_flags, out_retired, out_wb_addr and out_wb_data = 0.
  - out_wb_valid = 0.
- RESET has priority over a write in the same cycle; a write coincident with RESET is lost.
- After RESET deasserts, the first commit occurs on the first rising edge.
- Write latency: the value is in the bank from the next edge. Read latency is zero through the bypass.
- Read during write, same address, same cycle: the read returns the new value.
- Different addresses: the read returns the stored value.
- Two consecutive writes to the same register: the second wins; each is visible via the bypass in its own cycle.
- A flag update is visible on out_flags one edge after the commit. There is no flag bypass.

## Test plan
- Reset: assert RESET mid-run after writes → all rd_data = 0, out_flags = 0, out_retired = 0 and out_wb_valid = 0 immediately, without waiting for a clock edge.
- Source mux:
  - S_MXRB = 00, WC = 3, alu_res = 0x1234 → reg3 = 0x1234.
  - S_MXRB = 01, WC = 4, PR = 0xDEADBEEF → reg4 = 0xDEADBEEF.
  - S_MXRB = 10, WC = 15, PC = 0x40 → reg15 = 0x40.
  - S_MXRB = 11, W_RB = 1, WC = 5 → reg5 unchanged and out_wb_valid = 0.
- Bypass: write 0xAAAA5555 to reg7 with rd_addr_a = rd_addr_b = 7 → both reads return 0xAAAA5555 in the write cycle; the next cycle with no write returns the same from storage.
- Flags:
  - out_flags = 0000, in_flags = 1111, W_RF = 010 → out_flags = 0010.
  - Then in_flags = 1000, W_RF = 100 → out_flags = 1010.
  - ENABLE = 0 with W_RF = 111 → no change.
- Stall and counter:
  - 5 enabled cycles, 3 stalled, 2 enabled → out_retired = 7. No writes occur during the stalls.
  - Preload out_retired = 0xFFFFFFFF, one enabled cycle → out_retired = 0.
- Forward record: write reg2 = 0x99 → next cycle out_wb_valid = 1, out_wb_addr = 2, out_wb_data = 0x99. A following bubble gives out_wb_valid = 0 while addr and data hold.
